// File: rtl/loctag_adc_pkg.sv
// Shared ADC link definitions: frame geometry defaults and the responder/reader FSM encoding.
package loctag_adc_pkg;

    localparam int unsigned ADC_DATA_W      = 12;
    localparam int unsigned ADC_LEAD_ZEROS  = 4;
    localparam int unsigned ADC_FRAME_LEN   = 16;
    localparam int unsigned ADC_SYNC_STAGES = 2;
    localparam int unsigned ADC_COUNT_W     = 16;

    typedef enum logic [1:0] {
        ADC_ST_IDLE  = 2'd0,
        ADC_ST_SHIFT = 2'd1,
        ADC_ST_TAIL  = 2'd2
    } adc_state_e;

endpackage : loctag_adc_pkg

// File: rtl/adc_edge_sync.sv
// Synchronizes one asynchronous input into clk and flags its rising/falling edges.
// Edge flags stay quiet until the chain has been refilled after reset, so a line
// that is already low when reset releases is not mistaken for a new edge.
module adc_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic rise_c_o,
    output logic fall_c_o
);

    localparam int unsigned PRIME_MAX = SYNC_STAGES + 1;
    localparam int unsigned PRIME_W   = $clog2(PRIME_MAX + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [PRIME_W-1:0]     prime_q;
    logic                   primed_c;
    logic                   level_c;

    assign level_c  = sync_q[SYNC_STAGES-1];
    assign primed_c = (prime_q == PRIME_W'(PRIME_MAX));

    // Synchronizer chain, previous-level flop and post-reset priming counter
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= {SYNC_STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
            prime_q <= '0;
        end else begin
            sync_q  <= SYNC_STAGES'({sync_q, async_i});
            prev_q  <= level_c;
            if (!primed_c) begin
                prime_q <= prime_q + PRIME_W'(1);
            end
        end
    end

    assign rise_c_o = primed_c & ~prev_q &  level_c;
    assign fall_c_o = primed_c &  prev_q & ~level_c;

endmodule : adc_edge_sync

// File: rtl/adc_spi_responder.sv
// Serial-ADC responder: answers each adc_cs frame with LEAD_ZEROS zeros, a DATA_W-bit
// sample MSB first, then zero padding up to FRAME_LEN bits. All link inputs are
// oversampled in the clk domain.
// Build option: define ADC_RESP_PATTERN_EN to replace the sample_in path with an
// internal ramp that advances once per completed frame.
module adc_spi_responder
    import loctag_adc_pkg::*;
#(
    parameter int unsigned DATA_W      = ADC_DATA_W,
    parameter int unsigned LEAD_ZEROS  = ADC_LEAD_ZEROS,
    parameter int unsigned FRAME_LEN   = ADC_FRAME_LEN,
    parameter int unsigned SYNC_STAGES = ADC_SYNC_STAGES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   adc_cs,
    input  logic                   adc_clk,
    output logic                   adc_so,
    input  logic [DATA_W-1:0]      sample_in,
    input  logic                   sample_in_valid,
    output logic                   sample_in_ready,
    output logic                   frame_done,
    output logic                   frame_abort,
    output logic                   underrun,
    output logic [ADC_COUNT_W-1:0] frame_count
);

    localparam int unsigned PAD_BITS = FRAME_LEN - LEAD_ZEROS - DATA_W;
    localparam int unsigned IDX_W    = $clog2(FRAME_LEN + 1);

    logic cs_rise_c;
    logic cs_fall_c;
    logic sclk_fall_c;
    logic sclk_rise_unused;

    adc_state_e             state_q;
    logic [FRAME_LEN-1:0]   shift_q;
    logic [IDX_W-1:0]       bit_idx_q;
    logic [IDX_W-1:0]       bit_idx_d;
    logic                   adc_so_q;
    logic                   frame_done_q;
    logic                   frame_abort_q;
    logic                   underrun_q;
    logic [ADC_COUNT_W-1:0] frame_count_q;
    logic [ADC_COUNT_W-1:0] frame_count_d;

    logic [DATA_W-1:0]      latch_data_c;
    logic                   latch_underrun_c;
    logic [FRAME_LEN-1:0]   shift_load_c;
    logic                   frame_start_c;
    logic                   frame_end_c;

    // Chip select: idles high, falls to open a frame
    adc_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_cs_sync (
        .clk      (clk),
        .reset    (reset),
        .async_i  (adc_cs),
        .rise_c_o (cs_rise_c),
        .fall_c_o (cs_fall_c)
    );

    // Serial clock: idles high, each falling edge advances one bit
    adc_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sclk_sync (
        .clk      (clk),
        .reset    (reset),
        .async_i  (adc_clk),
        .rise_c_o (sclk_rise_unused),
        .fall_c_o (sclk_fall_c)
    );

    assign frame_start_c = (state_q == ADC_ST_IDLE) && cs_fall_c;
    assign frame_end_c   = (state_q == ADC_ST_SHIFT) && !cs_rise_c && sclk_fall_c &&
                           (bit_idx_q == IDX_W'(FRAME_LEN - 1));
    assign shift_load_c  = FRAME_LEN'(latch_data_c) << PAD_BITS;
    assign bit_idx_d     = bit_idx_q + IDX_W'(1);
    assign frame_count_d = frame_count_q + ADC_COUNT_W'(1);

`ifdef ADC_RESP_PATTERN_EN
    logic [DATA_W-1:0] ramp_q;
    logic              unused_sample_in;

    assign unused_sample_in = ^{sample_in, sample_in_valid};
    assign latch_data_c     = ramp_q;
    assign latch_underrun_c = 1'b0;
    assign sample_in_ready  = 1'b0;

    // Test ramp: steps only when a frame completes, so aborted frames repeat their value
    always_ff @(posedge clk) begin
        if (reset) begin
            ramp_q <= '0;
        end else if (frame_end_c) begin
            ramp_q <= ramp_q + DATA_W'(1);
        end
    end
`else
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] last_q;
    logic              fresh_q;
    logic              ready_q;

    assign latch_data_c     = fresh_q ? hold_q : last_q;
    assign latch_underrun_c = ~fresh_q;
    assign sample_in_ready  = ready_q;

    // Holding register: a frame start consumes it, an accept in the same cycle refills it
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q  <= '0;
            last_q  <= '0;
            fresh_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            if (frame_start_c) begin
                last_q  <= latch_data_c;
                fresh_q <= 1'b0;
                ready_q <= 1'b1;
            end
            if (sample_in_valid && ready_q) begin
                hold_q  <= sample_in;
                fresh_q <= 1'b1;
                ready_q <= 1'b0;
            end
        end
    end
`endif

    // Frame FSM: shift register walks MSB-first, adc_so is presented from a flop
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ADC_ST_IDLE;
            shift_q       <= '0;
            bit_idx_q     <= '0;
            adc_so_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            underrun_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            underrun_q    <= 1'b0;
            case (state_q)
                ADC_ST_IDLE: begin
                    adc_so_q <= 1'b0;
                    if (cs_fall_c) begin
                        shift_q    <= shift_load_c;
                        bit_idx_q  <= '0;
                        adc_so_q   <= shift_load_c[FRAME_LEN-1];
                        underrun_q <= latch_underrun_c;
                        state_q    <= ADC_ST_SHIFT;
                    end
                end
                ADC_ST_SHIFT: begin
                    if (cs_rise_c) begin
                        frame_abort_q <= 1'b1;
                        adc_so_q      <= 1'b0;
                        state_q       <= ADC_ST_IDLE;
                    end else if (frame_end_c) begin
                        frame_done_q  <= 1'b1;
                        frame_count_q <= frame_count_d;
                        bit_idx_q     <= bit_idx_d;
                        adc_so_q      <= 1'b0;
                        state_q       <= ADC_ST_TAIL;
                    end else if (sclk_fall_c) begin
                        bit_idx_q <= bit_idx_d;
                        shift_q   <= shift_q << 1;
                        adc_so_q  <= shift_q[FRAME_LEN-2];
                    end
                end
                ADC_ST_TAIL: begin
                    adc_so_q <= 1'b0;
                    if (cs_rise_c) begin
                        state_q <= ADC_ST_IDLE;
                    end
                end
                default: begin
                    adc_so_q <= 1'b0;
                    state_q  <= ADC_ST_IDLE;
                end
            endcase
        end
    end

    assign adc_so      = adc_so_q;
    assign frame_done  = frame_done_q;
    assign frame_abort = frame_abort_q;
    assign underrun    = underrun_q;
    assign frame_count = frame_count_q;

endmodule : adc_spi_responder

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: a bus-functional SPI master with randomized timing,
// a transaction-level model of holding register / ramp / frame counter, and an idle
// monitor that checks the quiet-state outputs every cycle between frames.
module tb_adc_spi_responder;

    localparam int unsigned DW    = 12;
    localparam int unsigned FL    = 16;
    localparam int          CLK_P = 10;
    localparam int          K_FULL  = 0;
    localparam int          K_ABORT = 1;
    localparam int          K_RESET = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          adc_cs = 1'b1;
    logic          adc_clk = 1'b1;
    logic          adc_so;
    logic [DW-1:0] sample_in = '0;
    logic          sample_in_valid = 1'b0;
    logic          sample_in_ready;
    logic          frame_done;
    logic          frame_abort;
    logic          underrun;
    logic [15:0]   frame_count;

    int checks = 0;
    int failures = 0;

    // Model state
    logic [DW-1:0] m_hold = '0;
    logic [DW-1:0] m_last = '0;
    logic          m_fresh = 1'b0;
    logic [15:0]   m_count = '0;
    logic [DW-1:0] m_ramp = '0;
    logic          pend_valid = 1'b0;
    logic [DW-1:0] pend_val = '0;

    // Observations
    logic [FL-1:0] last_bits = '0;
    int            n_done = 0;
    int            n_abort = 0;
    int            n_und = 0;
    logic          quiet = 1'b0;

    adc_spi_responder dut (
        .clk             (clk),
        .reset           (reset),
        .adc_cs          (adc_cs),
        .adc_clk         (adc_clk),
        .adc_so          (adc_so),
        .sample_in       (sample_in),
        .sample_in_valid (sample_in_valid),
        .sample_in_ready (sample_in_ready),
        .frame_done      (frame_done),
        .frame_abort     (frame_abort),
        .underrun        (underrun),
        .frame_count     (frame_count)
    );

    always #(CLK_P / 2) clk = ~clk;

    initial begin
        #(3_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_ready();
`ifdef ADC_RESP_PATTERN_EN
        return 1'b0;
`else
        return !m_fresh;
`endif
    endfunction

    // Pulse counters for the frame in progress
    always @(negedge clk) begin
        if (frame_done)  n_done++;
        if (frame_abort) n_abort++;
        if (underrun)    n_und++;
    end

    // Idle compare: between frames the outputs must match the model every cycle
    always @(negedge clk) begin
        if (quiet) begin
            chk("idle_adc_so", 32'(adc_so), 32'd0);
            chk("idle_frame_count", 32'(frame_count), 32'(m_count));
            chk("idle_ready", 32'(sample_in_ready), 32'(exp_ready()));
            chk("idle_pulses", 32'({frame_done, frame_abort, underrun}), 32'd0);
        end
    end

    task automatic idle(input int n);
        quiet = 1'b1;
        repeat (n) @(posedge clk);
        quiet = 1'b0;
    endtask

    task automatic model_reset();
        m_hold = '0; m_last = '0; m_fresh = 1'b0; m_count = '0; m_ramp = '0; pend_valid = 1'b0;
    endtask

    // Data chosen at frame start and whether that counts as an underrun
    task automatic model_start(output logic [DW-1:0] data, output logic und);
`ifdef ADC_RESP_PATTERN_EN
        data = m_ramp;
        und  = 1'b0;
`else
        if (m_fresh) begin
            data = m_hold; und = 1'b0; m_fresh = 1'b0;
        end else begin
            data = m_last; und = 1'b1;
        end
        if (pend_valid) begin
            m_hold = pend_val; m_fresh = 1'b1; pend_valid = 1'b0;
        end
`endif
        m_last = data;
    endtask

    task automatic load(input logic [DW-1:0] v);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        sample_in = v;
        sample_in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sample_in_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        sample_in_valid = 1'b0;
        sample_in = DW'($urandom);
        chk("load_accepted", 32'(ok), 32'd1);
        if (ok) begin
            m_hold = v; m_fresh = 1'b1;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // One master frame; bit i is sampled just before the (i+1)-th falling edge
    task automatic run_frame(input int kind, input int k, input int extra);
        logic [DW-1:0] data;
        logic          und;
        logic [FL-1:0] exp_word;
        logic [FL-1:0] ones;
        logic [FL-1:0] mask;
        int            half;
        n_done = 0; n_abort = 0; n_und = 0;
        model_start(data, und);
        exp_word = FL'(data);
        half = int'($urandom_range(3, 6)) * CLK_P;
        last_bits = '0;
        adc_cs = 1'b0;
        #(2 * half + int'($urandom_range(0, 7)));
        for (int i = 0; i < FL; i++) begin
            if (kind == K_ABORT && i == k) break;
            if (kind == K_RESET && i == k) pulse_reset();
            last_bits[FL-1-i] = adc_so;
            adc_clk = 1'b0;
            #(half + int'($urandom_range(0, 7)));
            adc_clk = 1'b1;
            #(half + int'($urandom_range(0, 7)));
        end
        if (kind == K_FULL) begin
            for (int e = 0; e < extra; e++) begin
                adc_clk = 1'b0; #(half);
                adc_clk = 1'b1; #(half);
            end
        end
        adc_cs = 1'b1;
        repeat (8) @(posedge clk);
        ones = '1;
        mask = (k == 0) ? '0 : ~(ones >> k);
        if (kind == K_FULL) begin
            chk("frame_bits", 32'(last_bits), 32'(exp_word));
            chk("frame_done_cnt", 32'(n_done), 32'd1);
            chk("frame_abort_cnt", 32'(n_abort), 32'd0);
            m_count = m_count + 16'd1;
            m_ramp  = m_ramp + DW'(1);
        end else if (kind == K_ABORT) begin
            chk("abort_bits", 32'(last_bits), 32'(exp_word & mask));
            chk("abort_done_cnt", 32'(n_done), 32'd0);
            chk("abort_abort_cnt", 32'(n_abort), 32'd1);
        end else begin
            chk("reset_bits", 32'(last_bits), 32'(exp_word & mask));
            chk("reset_done_cnt", 32'(n_done), 32'd0);
            chk("reset_abort_cnt", 32'(n_abort), 32'd0);
        end
        chk("frame_underrun_cnt", 32'(n_und), 32'(und));
    endtask

    initial begin
        int kr;
        int kind;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("rst_adc_so", 32'(adc_so), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_ready", 32'(sample_in_ready), 32'(exp_ready()));
        idle(4);

`ifndef ADC_RESP_PATTERN_EN
        chk("rst_ready_lit", 32'(sample_in_ready), 32'd1);
        load(12'hA5C);
        run_frame(K_FULL, 0, 1);
        chk("t1_bits", 32'(last_bits), 32'h0A5C);
        chk("t1_count", 32'(frame_count), 32'd1);
        chk("t1_ready", 32'(sample_in_ready), 32'd1);
        idle(4);
        run_frame(K_FULL, 0, 0);
        chk("t2_bits", 32'(last_bits), 32'h0A5C);
        chk("t2_underrun", 32'(n_und), 32'd1);
        chk("t2_count", 32'(frame_count), 32'd2);
        idle(4);
        run_frame(K_ABORT, 7, 0);
        chk("t3_abort", 32'(n_abort), 32'd1);
        chk("t3_count", 32'(frame_count), 32'd2);
        chk("t3_adc_so", 32'(adc_so), 32'd0);
        idle(4);
        load(12'h3C1);
        run_frame(K_FULL, 0, 2);
        chk("t3_next_bits", 32'(last_bits), 32'h03C1);
        idle(4);
        load(12'h456);
        @(negedge clk);
        sample_in = 12'h123;
        sample_in_valid = 1'b1;
        pend_val = 12'h123;
        pend_valid = 1'b1;
        run_frame(K_FULL, 0, 0);
        chk("t4_bits_a", 32'(last_bits), 32'h0456);
        chk("t4_ready_held", 32'(sample_in_ready), 32'd0);
        @(negedge clk);
        sample_in_valid = 1'b0;
        idle(4);
        run_frame(K_FULL, 0, 0);
        chk("t4_bits_b", 32'(last_bits), 32'h0123);
        chk("t4_no_underrun", 32'(n_und), 32'd0);
        idle(4);
        run_frame(K_RESET, 10, 0);
        chk("t5_count", 32'(frame_count), 32'd0);
        chk("t5_ready", 32'(sample_in_ready), 32'd1);
        idle(4);
        run_frame(K_FULL, 0, 0);
        chk("t5_bits", 32'(last_bits), 32'h0000);
        chk("t5_underrun", 32'(n_und), 32'd1);
        idle(4);
`else
        run_frame(K_FULL, 0, 0);
        chk("p_bits0", 32'(last_bits), 32'h0000);
        idle(4);
        run_frame(K_FULL, 0, 1);
        chk("p_bits1", 32'(last_bits), 32'h0001);
        idle(4);
        run_frame(K_ABORT, 5, 0);
        chk("p_abort", 32'(n_abort), 32'd1);
        idle(4);
        run_frame(K_FULL, 0, 0);
        chk("p_bits2_repeat", 32'(last_bits), 32'h0002);
        chk("p_no_underrun", 32'(n_und), 32'd0);
        chk("p_count", 32'(frame_count), 32'd3);
        idle(4);
`endif

        for (int f = 0; f < 36; f++) begin
            kr = int'($urandom_range(0, 9));
            kind = (kr < 7) ? K_FULL : ((kr < 9) ? K_ABORT : K_RESET);
`ifndef ADC_RESP_PATTERN_EN
            if (!m_fresh && ($urandom_range(0, 1) == 1)) load(DW'($urandom));
`else
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                sample_in = DW'($urandom);
                sample_in_valid = 1'b1;
                repeat (3) @(negedge clk);
                sample_in_valid = 1'b0;
            end
`endif
            run_frame(kind, int'($urandom_range(0, FL - 1)), int'($urandom_range(0, 2)));
            idle(int'($urandom_range(2, 6)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_adc_spi_responder
